// File: rtl/ir_nec_pkg.sv
// Shared types and default timing for the NEC IR receiver.
// Timing values are in 100 us ticks of clk_10KHz.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LO,
    LEAD_HI,
    BIT_LO,
    BIT_HI,
    STOP_LO,
    REP_LO,
    CHECK
  } stateT;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMING  = 2'b01,
    ERR_CHECK   = 2'b10,
    ERR_OVERRUN = 2'b11
  } errCodeT;

  localparam logic [7:0] DEF_LEAD_MIN = 8'd80;
  localparam logic [7:0] DEF_LEAD_MAX = 8'd110;
  localparam logic [7:0] DEF_SPC_MIN  = 8'd35;
  localparam logic [7:0] DEF_SPC_MAX  = 8'd50;
  localparam logic [7:0] DEF_REP_MIN  = 8'd17;
  localparam logic [7:0] DEF_REP_MAX  = 8'd28;
  localparam logic [7:0] DEF_MARK_MIN = 8'd3;
  localparam logic [7:0] DEF_MARK_MAX = 8'd9;
  localparam logic [7:0] DEF_ONE_TH   = 8'd11;
  localparam logic [7:0] DEF_BIT_MAX  = 8'd24;

  function automatic logic inRange(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_rx_edge_timer.sv
// Input conditioning for the IR line: 2-FF synchroniser, edge detect,
// and a saturating counter giving the length of the current level.
// On an edge cycle levelCnt still holds the length of the level just ended.
module ir_edge_timer (
  input  logic       clk_10KHz,
  input  logic       stateReset,
  input  logic       IR,
  output logic       riseEdge,
  output logic       fallEdge,
  output logic [7:0] levelCnt
);

  logic irMeta;
  logic irSync;
  logic irPrev;

  // Synchronise the raw line and keep one cycle of history for edge detect
  always_ff @(posedge clk_10KHz or posedge stateReset) begin
    if (stateReset) begin
      irMeta <= 1'b1;
      irSync <= 1'b1;
      irPrev <= 1'b1;
    end else begin
      irMeta <= IR;
      irSync <= irMeta;
      irPrev <= irSync;
    end
  end

  assign riseEdge = irSync & ~irPrev;
  assign fallEdge = ~irSync & irPrev;

  // Level length: restart at 1 on any edge, otherwise count up and hold at 255
  always_ff @(posedge clk_10KHz or posedge stateReset) begin
    if (stateReset) begin
      levelCnt <= 8'd0;
    end else if (riseEdge || fallEdge) begin
      levelCnt <= 8'd1;
    end else if (levelCnt != 8'hFF) begin
      levelCnt <= levelCnt + 8'd1;
    end
  end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame receiver: decodes leader, data bits, stop mark and repeat
// codes from an active-low IR line and holds one frame for the consumer.
//
//   state   | meaning
//   IDLE    | line idle, waiting for a falling edge
//   LEAD_LO | leader mark (low)
//   LEAD_HI | leader space (high), selects data frame or repeat code
//   BIT_LO  | bit mark (low)
//   BIT_HI  | bit space (high), its length gives the bit value
//   STOP_LO | stop mark after the last data bit
//   REP_LO  | mark closing a repeat code
//   CHECK   | one-cycle integrity check and frame hand-off
module ir_nec_rx import ir_nec_pkg::*; #(
  parameter int         NBITS     = 32,
  parameter logic [7:0] LEAD_MIN  = DEF_LEAD_MIN,
  parameter logic [7:0] LEAD_MAX  = DEF_LEAD_MAX,
  parameter logic [7:0] SPC_MIN   = DEF_SPC_MIN,
  parameter logic [7:0] SPC_MAX   = DEF_SPC_MAX,
  parameter logic [7:0] REP_MIN   = DEF_REP_MIN,
  parameter logic [7:0] REP_MAX   = DEF_REP_MAX,
  parameter logic [7:0] MARK_MIN  = DEF_MARK_MIN,
  parameter logic [7:0] MARK_MAX  = DEF_MARK_MAX,
  parameter logic [7:0] ONE_TH    = DEF_ONE_TH,
  parameter logic [7:0] BIT_MAX   = DEF_BIT_MAX,
  parameter bit         CHECK_INV = 1'b1,
  parameter bit         REPEAT_EN = 1'b1
) (
  input  logic             clk_10KHz,
  input  logic             stateReset,
  input  logic             IR,
  input  logic             data_ack,
  output logic             data_valid,
  output logic [NBITS-1:0] frame,
  output logic [3:0]       key,
  output logic             repeat_pulse,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic             busy
);

  localparam int IDXW    = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int KEY_LSB = (NBITS == 32) ? 16 : 0;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBITS - 1);
  // The leader space timeout must allow the longer of the two accepted spaces
  localparam logic [7:0] HI_MAX = (REPEAT_EN && (REP_MAX > SPC_MAX)) ? REP_MAX : SPC_MAX;

  stateT            state;
  logic [IDXW-1:0]  bitIdx;
  logic [NBITS-1:0] shiftReg;
  logic [31:0]      shiftPad;
  logic             lastOk;
  logic             riseEdge;
  logic             fallEdge;
  logic [7:0]       levelCnt;
  logic [7:0]       curMax;
  logic             edgeBad;
  logic             timingErr;
  logic             checkPass;

  ir_edge_timer u_edgeTimer (
    .clk_10KHz (clk_10KHz),
    .stateReset(stateReset),
    .IR        (IR),
    .riseEdge  (riseEdge),
    .fallEdge  (fallEdge),
    .levelCnt  (levelCnt)
  );

  assign shiftPad  = 32'(shiftReg);
  assign checkPass = !(CHECK_INV && (NBITS == 32)) ||
                     ((shiftPad[15:8] == ~shiftPad[7:0]) && (shiftPad[31:24] == ~shiftPad[23:16]));
  assign key  = frame[KEY_LSB +: 4];
  assign busy = (state != IDLE);

  // Timing violation: an edge closing a level of bad length, or a level outliving its maximum
  always_comb begin
    curMax  = 8'hFF;
    edgeBad = 1'b0;
    case (state)
      LEAD_LO: begin
        curMax  = LEAD_MAX;
        edgeBad = riseEdge && !inRange(levelCnt, LEAD_MIN, LEAD_MAX);
      end
      LEAD_HI: begin
        curMax  = HI_MAX;
        edgeBad = fallEdge && !inRange(levelCnt, SPC_MIN, SPC_MAX) &&
                  !(REPEAT_EN && inRange(levelCnt, REP_MIN, REP_MAX));
      end
      BIT_LO, STOP_LO, REP_LO: begin
        curMax  = MARK_MAX;
        edgeBad = riseEdge && !inRange(levelCnt, MARK_MIN, MARK_MAX);
      end
      BIT_HI: begin
        curMax  = BIT_MAX;
        edgeBad = fallEdge && (levelCnt > BIT_MAX);
      end
      default: ;
    endcase
    timingErr = (state != IDLE) && (state != CHECK) &&
                (edgeBad || (!(riseEdge || fallEdge) && (levelCnt > curMax)));
  end

  // Protocol FSM with registered frame, status and pulse outputs
  always_ff @(posedge clk_10KHz or posedge stateReset) begin
    if (stateReset) begin
      state        <= IDLE;
      bitIdx       <= '0;
      shiftReg     <= '0;
      frame        <= '0;
      data_valid   <= 1'b0;
      repeat_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      err_code     <= ERR_NONE;
      lastOk       <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      if (data_ack && data_valid) data_valid <= 1'b0;
      if (timingErr) begin
        state     <= IDLE;
        err_pulse <= 1'b1;
        err_code  <= ERR_TIMING;
        lastOk    <= 1'b0;
      end else begin
        case (state)
          IDLE:    if (fallEdge) state <= LEAD_LO;
          LEAD_LO: if (riseEdge) state <= LEAD_HI;
          LEAD_HI: begin
            if (fallEdge) begin
              if (inRange(levelCnt, SPC_MIN, SPC_MAX)) begin
                state  <= BIT_LO;
                bitIdx <= '0;
              end else begin
                state <= REP_LO;
              end
            end
          end
          BIT_LO:  if (riseEdge) state <= BIT_HI;
          BIT_HI: begin
            if (fallEdge) begin
              shiftReg[bitIdx] <= (levelCnt >= ONE_TH);
              if (bitIdx == LAST_IDX) begin
                state <= STOP_LO;
              end else begin
                bitIdx <= bitIdx + 1'b1;
                state  <= BIT_LO;
              end
            end
          end
          STOP_LO: if (riseEdge) state <= CHECK;
          REP_LO: begin
            if (riseEdge) begin
              repeat_pulse <= lastOk;
              state        <= IDLE;
            end
          end
          CHECK: begin
            state <= IDLE;
            if (!checkPass) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_CHECK;
            end else if (!data_valid || data_ack) begin
              frame      <= shiftReg;
              data_valid <= 1'b1;
              lastOk     <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= ERR_OVERRUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_rx.sv
// Bench for ir_nec_rx: waveforms are lists of level durations (low first);
// a list-walking protocol model predicts each outcome, and a per-cycle
// compare process checks the held frame against the model when idle.
module tb_ir_nec_rx;

  typedef int waveT[$];

  localparam int T_ERR = 0, T_DATA = 1, T_REP = 2;
  localparam int INF = 1000;

  logic        clk_10KHz = 1'b0;
  logic        stateReset = 1'b0;
  logic        IR = 1'b1;
  logic        data_ack = 1'b0;
  logic        data_valid;
  logic [31:0] frame;
  logic [3:0]  key;
  logic        repeat_pulse;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        busy;

  ir_nec_rx dut (
    .clk_10KHz   (clk_10KHz),
    .stateReset  (stateReset),
    .IR          (IR),
    .data_ack    (data_ack),
    .data_valid  (data_valid),
    .frame       (frame),
    .key         (key),
    .repeat_pulse(repeat_pulse),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expFrame = '0;
  logic        expValid = 1'b0;
  logic        lastOk = 1'b0;
  bit          settled = 1'b0;
  int          rCnt = 0;
  int          eCnt = 0;
  logic [1:0]  lastCode = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse monitor plus per-cycle comparison against the model while idle
  always begin
    @(posedge clk_10KHz);
    #2;
    if (repeat_pulse === 1'b1) rCnt++;
    if (err_pulse === 1'b1) begin
      eCnt++;
      lastCode = err_code;
    end
    if (settled) begin
      check("data_valid", 32'(data_valid), 32'(expValid));
      check("frame", frame, expFrame);
      check("key", 32'(key), 32'(expFrame[19:16]));
      check("busy idle", 32'(busy), 32'd0);
    end
  end

  function automatic int at(input waveT q, input int i);
    return (i < q.size()) ? q[i] : INF;
  endfunction

  function automatic bit inR(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Protocol model: walk the level list with the NEC timing windows
  function automatic int classify(input waveT q, output logic [31:0] bits);
    int hiLen;
    bits = '0;
    if (!inR(at(q, 0), 80, 110)) return T_ERR;
    hiLen = at(q, 1);
    if (inR(hiLen, 35, 50)) begin
      for (int i = 0; i < 32; i++) begin
        if (!inR(at(q, 2 + 2 * i), 3, 9)) return T_ERR;
        if (at(q, 3 + 2 * i) > 24) return T_ERR;
        bits[i] = (at(q, 3 + 2 * i) >= 11);
      end
      if (!inR(at(q, 66), 3, 9)) return T_ERR;
      return T_DATA;
    end
    if (inR(hiLen, 17, 28)) return inR(at(q, 2), 3, 9) ? T_REP : T_ERR;
    return T_ERR;
  endfunction

  function automatic waveT buildFrame(input logic [31:0] f, input int lead, input int hi,
                                      input int mark, input int zs, input int os, input int stp);
    waveT q;
    q.push_back(lead);
    q.push_back(hi);
    for (int i = 0; i < 32; i++) begin
      q.push_back(mark);
      q.push_back(f[i] ? os : zs);
    end
    q.push_back(stp);
    return q;
  endfunction

  function automatic waveT stdFrame(input logic [31:0] f);
    return buildFrame(f, 90, 45, 6, 6, 17, 6);
  endfunction

  task automatic sendWave(input waveT q, input bit ackInCheck);
    foreach (q[i]) begin
      IR = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (q[i]) @(negedge clk_10KHz);
    end
    IR = 1'b1;
    if (ackInCheck) begin
      repeat (3) @(negedge clk_10KHz);
      data_ack = 1'b1;
      @(negedge clk_10KHz);
      data_ack = 1'b0;
    end
  endtask

  task automatic runWave(input string name, input waveT q, input bit ackInCheck);
    logic [31:0] bits;
    int          kind;
    int          expR;
    int          expE;
    logic [1:0]  expCode;
    expR = 0;
    expE = 0;
    expCode = 2'b00;
    settled = 1'b0;
    rCnt = 0;
    eCnt = 0;
    kind = classify(q, bits);
    sendWave(q, ackInCheck);
    repeat (40) @(negedge clk_10KHz);
    case (kind)
      T_ERR: begin
        expE = 1;
        expCode = 2'b01;
        lastOk = 1'b0;
      end
      T_REP: begin
        if (lastOk) expR = 1;
      end
      default: begin
        if ((bits[15:8] != ~bits[7:0]) || (bits[31:24] != ~bits[23:16])) begin
          expE = 1;
          expCode = 2'b10;
        end else if (!expValid || ackInCheck) begin
          expFrame = bits;
          expValid = 1'b1;
          lastOk = 1'b1;
        end else begin
          expE = 1;
          expCode = 2'b11;
        end
      end
    endcase
    check({name, " repeat pulses"}, 32'(rCnt), 32'(expR));
    check({name, " err pulses"}, 32'(eCnt), 32'(expE));
    if (expE != 0) check({name, " err code"}, 32'(lastCode), 32'(expCode));
    settled = 1'b1;
  endtask

  task automatic doAck();
    settled = 1'b0;
    data_ack = 1'b1;
    @(negedge clk_10KHz);
    data_ack = 1'b0;
    expValid = 1'b0;
    repeat (3) @(negedge clk_10KHz);
    settled = 1'b1;
  endtask

  task automatic checkResetOutputs(input string name);
    check({name, " data_valid"}, 32'(data_valid), 32'd0);
    check({name, " frame"}, frame, 32'd0);
    check({name, " key"}, 32'(key), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " repeat_pulse"}, 32'(repeat_pulse), 32'd0);
    check({name, " err_pulse"}, 32'(err_pulse), 32'd0);
    check({name, " err_code"}, 32'(err_code), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    waveT q;
    #2 stateReset = 1'b1;
    #1 checkResetOutputs("por");
    repeat (3) @(negedge clk_10KHz);
    stateReset = 1'b0;
    repeat (5) @(negedge clk_10KHz);
    settled = 1'b1;

    runWave("repeat after reset", '{90, 22, 6}, 1'b0);
    check("repeat after reset literal", 32'(rCnt), 32'd0);

    runWave("frame A", stdFrame(32'hFA05FF00), 1'b0);
    check("frame A literal", frame, 32'hFA05FF00);
    check("frame A key literal", 32'(key), 32'h5);
    check("frame A valid literal", 32'(data_valid), 32'd1);

    runWave("repeat after A", '{90, 22, 6}, 1'b0);
    check("repeat after A literal", 32'(rCnt), 32'd1);

    runWave("leader 60", '{60}, 1'b0);
    check("leader 60 code literal", 32'(lastCode), 32'd1);
    check("leader 60 valid literal", 32'(data_valid), 32'd1);

    runWave("repeat after terr", '{90, 22, 6}, 1'b0);

    runWave("overrun B", stdFrame(32'hE11EA55A), 1'b0);
    check("overrun code literal", 32'(lastCode), 32'd3);
    check("overrun keeps A literal", frame, 32'hFA05FF00);

    runWave("B ack in check", stdFrame(32'hE11EA55A), 1'b1);
    check("B literal", frame, 32'hE11EA55A);
    check("B key literal", 32'(key), 32'hE);
    doAck();

    runWave("check error", stdFrame(32'hFB05FF00), 1'b0);
    check("check error code literal", 32'(lastCode), 32'd2);

    runWave("boundary C", buildFrame(32'h7F80BF40, 110, 35, 3, 10, 11, 3), 1'b0);
    doAck();
    runWave("boundary D", buildFrame(32'hFF00FF00, 80, 50, 9, 4, 24, 9), 1'b0);
    runWave("repeat hi 17", '{90, 17, 9}, 1'b0);
    runWave("repeat hi 28", '{80, 28, 3}, 1'b0);
    doAck();

    runWave("lead 111", '{111}, 1'b0);
    runWave("lead 150 timeout", '{150}, 1'b0);
    runWave("lead 79", '{79}, 1'b0);
    runWave("hi 30", '{90, 30, 6}, 1'b0);
    runWave("hi 51", '{90, 51, 6}, 1'b0);
    runWave("hi 16", '{90, 16, 6}, 1'b0);
    runWave("mark 10", '{90, 45, 10}, 1'b0);
    runWave("mark 2", '{90, 45, 2}, 1'b0);
    runWave("space 25", '{90, 45, 6, 25, 6}, 1'b0);
    runWave("space timeout", '{90, 45, 6}, 1'b0);
    runWave("stop 10", buildFrame(32'h8D72F906, 90, 45, 6, 6, 17, 10), 1'b0);
    runWave("repeat after stop err", '{90, 22, 6}, 1'b0);

    runWave("frame E", stdFrame(32'h8D72F906), 1'b0);

    settled = 1'b0;
    q = stdFrame(32'hE11EA55A);
    for (int i = 0; i < 36; i++) begin
      IR = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (q[i]) @(negedge clk_10KHz);
    end
    IR = 1'b0;
    repeat (3) @(negedge clk_10KHz);
    check("busy mid frame literal", 32'(busy), 32'd1);
    stateReset = 1'b1;
    IR = 1'b1;
    #1 checkResetOutputs("mid-frame reset");
    repeat (2) @(negedge clk_10KHz);
    stateReset = 1'b0;
    expFrame = '0;
    expValid = 1'b0;
    lastOk = 1'b0;
    repeat (20) @(negedge clk_10KHz);
    settled = 1'b1;

    runWave("frame after reset", stdFrame(32'h8D72F906), 1'b0);
    check("frame after reset literal", frame, 32'h8D72F906);
    check("key after reset literal", 32'(key), 32'h2);
    doAck();

    settled = 1'b0;
    repeat (2) @(negedge clk_10KHz);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ir_nec_rx.md
IR_NEC_RX -- requirements
Module: ir_nec_rx

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, meaning the number of data bits per frame (multiple of 8, 8..32).
REQ-002 The block SHALL have parameter LEAD_MIN/LEAD_MAX, default 80/110, meaning the valid leader-low length in ticks.
REQ-003 The block SHALL have parameter SPC_MIN/SPC_MAX, default 35/50, meaning the valid data-frame leader-high length in ticks.
REQ-004 The block SHALL have parameter REP_MIN/REP_MAX, default 17/28, meaning the valid repeat-code leader-high length in ticks.
REQ-005 The block SHALL have parameter MARK_MIN/MARK_MAX, default 3/9, meaning the valid bit-mark or stop-mark low length in ticks.
REQ-006 The block SHALL have parameter ONE_TH/BIT_MAX, default 11/24, meaning: bit space < ONE_TH decodes 0; ONE_TH..BIT_MAX decodes 1.
REQ-007 The block SHALL have parameter CHECK_INV/REPEAT_EN, default 1/1, meaning the inverted-byte check enable and repeat-code enable.
REQ-008 The block SHALL have port clk_10KHz, input, 1 bit: the clock, one tick per 100 us.
REQ-009 The block SHALL have port stateReset, input, 1 bit: the reset, asynchronous, active-high.
REQ-010 The block SHALL have port IR, input, 1 bit: the raw IR receiver output, active-low, idle high, asynchronous.
REQ-011 The block SHALL have port data_ack, input, 1 bit: consumer acknowledge of the held frame.
REQ-012 The block SHALL have port data_valid, output, 1 bit: frame held and unacknowledged.
REQ-013 The block SHALL have port frame, output, NBITS bits: the decoded frame, LSB received first.
REQ-014 The block SHALL have port key, output, 4 bits: the low nibble of the command byte (bits 19:16 when NBITS=32, else bits 3:0).
REQ-015 The block SHALL have port repeat_pulse, output, 1 bit: a one-cycle pulse on an accepted repeat code.
REQ-016 The block SHALL have port err_pulse/err_code, output, 1/2 bits: a one-cycle error pulse; code 01 timing, 10 check, 11 overrun.
REQ-017 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 IR SHALL pass a 2-FF synchroniser; all decisions SHALL use the synchronised level, adding 2 cycles of latency.
REQ-019 An 8-bit level counter SHALL reset to 1 on each synchronised edge, increment each cycle otherwise, and saturate at 255.
REQ-020 The FSM SHALL have states IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP_LO, REP_LO, CHECK.
REQ-021 IDLE SHALL move to LEAD_LO on a synchronised falling edge and SHALL have no timeout.
REQ-022 On a rising edge in LEAD_LO, a count in LEAD_MIN..LEAD_MAX SHALL move the FSM to LEAD_HI; otherwise the FSM SHALL flag a timing error.
REQ-023 On a falling edge in LEAD_HI, a count in SPC range SHALL move the FSM to BIT_LO with the bit index cleared; a count in REP range with REPEAT_EN=1 SHALL move it to REP_LO; otherwise the FSM SHALL flag a timing error.
REQ-024 On a rising edge in BIT_LO, a count in MARK range SHALL move the FSM to BIT_HI.
REQ-025 On a falling edge in BIT_HI, the space SHALL be decoded per REQ-006 and shifted in at the bit index; after NBITS bits the FSM SHALL move to STOP_LO, else to BIT_LO.
REQ-026 On a rising edge in STOP_LO, a count in MARK range SHALL move the FSM to CHECK.
REQ-027 CHECK SHALL last one cycle. With CHECK_INV=1, byte1 must equal ~byte0 and byte3 must equal ~byte2 (NBITS=32 only); otherwise the block SHALL flag a check error.
REQ-028 On a check pass with data_valid=0, or with data_ack high in that same cycle, the block SHALL load frame, set data_valid next cycle, and set the last_ok flag.
REQ-029 On a check pass with data_valid=1 and no data_ack, the new frame SHALL be dropped, the held frame retained, and an overrun error flagged.
REQ-030 On a rising edge in REP_LO with the mark in range, the block SHALL pulse repeat_pulse only if last_ok=1; frame and data_valid SHALL be unchanged.
REQ-031 In any non-IDLE state, a level exceeding the state maximum (LEAD_MAX, SPC_MAX, MARK_MAX, BIT_MAX) while still in that level SHALL flag a timing error immediately.
REQ-032 Any flagged error SHALL pulse err_pulse for 1 cycle with its code, return the FSM to IDLE, and leave frame and data_valid untouched; a timing error SHALL also clear last_ok.
REQ-033 data_valid SHALL clear in the cycle after data_ack is sampled high; data_ack while data_valid=0 SHALL be ignored.

Reset
REQ-034 stateReset SHALL asynchronously force: FSM to IDLE; all counters to 0; synchroniser to 1; frame to 0; data_valid, repeat_pulse, err_pulse, last_ok, and busy to 0; err_code to 00.
REQ-035 Reset mid-frame SHALL discard partial bits; after release, decoding SHALL begin only at the next falling edge.

Structure
REQ-036 Package ir_nec_pkg SHALL hold the FSM state enum, the err_code enum, and the default timing constants.
REQ-037 Sub-module ir_edge_timer SHALL contain the synchroniser, edge detection, and saturating level counter.

Verification
REQ-038 Sending 90 low / 45 high, then addr 0x00, ~0x00, cmd 0x05, ~0x05, then stop, SHALL give frame=0xFA05FF00, key=5, and data_valid=1 until data_ack.
REQ-039 Sending 90 low / 22 high / 6 low after a good frame SHALL give repeat_pulse=1 for 1 cycle with frame unchanged; the same sequence after reset SHALL give no pulse.
REQ-040 A leader low of 60 ticks SHALL give err_code=01, return the FSM to IDLE, and leave data_valid unchanged.
REQ-041 A frame with cmd 0x05 and inverse 0xFB SHALL give err_code=10 and data_valid=0.
REQ-042 A second good frame sent without ack SHALL give err_code=11 and retain the first frame; the same frame with ack in the CHECK cycle SHALL load the new frame.
REQ-043 stateReset asserted at bit 17 SHALL give all outputs at reset values, and a following full frame SHALL decode correctly.
